vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HD, default 640: active pixels per line.
REQ-002 SHALL have parameters HF, HS, HB, defaults 16, 96, 48: horizontal front porch, sync width and back porch in pixels; HT = HD+HF+HS+HB.
REQ-003 SHALL have parameters VD, VF, VS, VB, defaults 480, 10, 2, 33: vertical active lines, front porch, sync width and back porch in lines; VT = VD+VF+VS+VB.
REQ-004 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-005 SHALL have parameter LEAD, default 0, range 0..7: ce-ticks by which fetch outputs lead display outputs.
REQ-006 SHALL have parameter FCW, default 8: width of frame_cnt.
REQ-007 SHALL have port pclk, input, 1 bit: the only clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port ce, input, 1 bit: pixel enable; timing advances only on pclk edges with ce=1.
REQ-010 SHALL have ports fetch_h and fetch_v, output, 10 bits each: pixel coordinate to request from memory; 0 outside the active area.
REQ-011 SHALL have port fetch_valid, output, 1 bit: fetch coordinate is inside the active area.
REQ-012 SHALL have ports h_cnt and v_cnt, output, 10 bits each: coordinate currently displayed; 0 outside the active area.
REQ-013 SHALL have ports valid, hsync and vsync, output, 1 bit each: display-aligned active flag and sync signals.
REQ-014 SHALL have ports line_start and frame_start, output, 1 bit each: single-pclk pulses.
REQ-015 SHALL have port frame_cnt, output, FCW bits: count of completed frames.

Function
REQ-016 Internal counters px (0..HT-1) and ln (0..VT-1) SHALL advance on a ce=1 edge: px increments; at px=HT-1, px wraps to 0 and ln increments; at ln=VT-1, ln wraps to 0.
REQ-017 Fetch-side signals SHALL be combinational from px and ln: fetch_valid = (px<HD && ln<VD); fetch_h = px when px<HD, else 0; fetch_v = ln when ln<VD, else 0.
REQ-018 Raw hsync SHALL be asserted for HD+HF <= px < HD+HF+HS; raw vsync SHALL be asserted for VD+VF <= ln < VD+VF+VS; asserted level per HSYNC_POL/VSYNC_POL.
REQ-019 Display-side signals {valid, h_cnt, v_cnt, hsync, vsync} SHALL equal the fetch-side signals and raw syncs delayed through a LEAD-stage pipeline; each stage shifts only on a ce=1 edge. LEAD=0 means no pipeline.
REQ-020 line_start SHALL be 1 for exactly the pclk cycles where ce=1, px=0 and ln<VD.
REQ-021 frame_start SHALL be 1 for exactly the pclk cycles where ce=1, px=0 and ln=0.
REQ-022 frame_cnt SHALL increment, modulo 2^FCW, on a ce=1 edge where px=HT-1 and ln=VT-1.
REQ-023 With ce=0, all state SHALL hold, and line_start and frame_start SHALL be 0.
REQ-024 Counter comparisons SHALL use at least 11-bit arithmetic so that HT and VT values up to 2047 do not overflow.

Reset
REQ-025 While reset=0, the following SHALL hold immediately, independent of pclk:
- px, ln, frame_cnt = 0;
- every pipeline stage holds valid=0, h_cnt=v_cnt=0 and deasserted syncs;
- line_start = frame_start = 0.
REQ-026 After reset is released, the first ce=1 edge SHALL advance px from 0 to 1; display outputs SHALL show the blank state for the first LEAD ce-ticks.
REQ-027 A reset asserted mid-frame SHALL abort the frame; the restart SHALL begin at px=0, ln=0 with frame_cnt=0.

Verification
REQ-028 Defaults with ce=1: period SHALL be 800 pclk per line and 420000 pclk per frame; hsync=0 exactly at px 656..751; vsync=0 exactly at lines 490..491.
REQ-029 LEAD=2 with ce=1: when fetch_h=5, h_cnt SHALL be 3; valid SHALL rise exactly 2 pclk after fetch_valid rises at px=0.
REQ-030 ce=1 every 4th pclk: one line SHALL take 3200 pclk; line_start and frame_start SHALL each be 1 pclk wide and coincide with ce.
REQ-031 HSYNC_POL=1, VSYNC_POL=1: sync levels SHALL be inverted relative to REQ-028, with identical timing windows.
REQ-032 Reset=0 at px=300, ln=200 with no pclk edge: outputs SHALL immediately match REQ-025; after release, frame_start SHALL appear on the first ce=1 cycle.
REQ-033 FCW=2 with ce=1: after 5 complete frames, frame_cnt SHALL equal 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator. Free-running pixel (px) and line (ln) counters
//   advance on pixel-enable ticks. Fetch-side outputs are combinational from
//   the counters. Display-side outputs are the same values delayed by LEAD
//   ticks, so that memory read latency can be hidden.
//
//   Ports
//     pclk          pixel clock (only clock)
//     reset         asynchronous, active-low reset
//     ce            pixel enable; timing advances only on ce=1 edges
//     fetch_h/v     coordinate to request from memory (0 outside active)
//     fetch_valid   fetch coordinate lies inside the active area
//     h_cnt/v_cnt   coordinate currently displayed (LEAD ticks behind fetch)
//     valid         display-aligned active flag
//     hsync/vsync   display-aligned syncs, asserted level per *_POL
//     line_start    one-pclk pulse at px=0 of every active line (ce=1 only)
//     frame_start   one-pclk pulse at px=0, ln=0 (ce=1 only)
//     frame_cnt     completed frames, wraps modulo 2^FCW

module vga_timing_gen #(
   parameter int unsigned HD        = 640,
   parameter int unsigned HF        = 16,
   parameter int unsigned HS        = 96,
   parameter int unsigned HB        = 48,
   parameter int unsigned VD        = 480,
   parameter int unsigned VF        = 10,
   parameter int unsigned VS        = 2,
   parameter int unsigned VB        = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned LEAD      = 0,
   parameter int unsigned FCW       = 8
) (
   input  logic           pclk,
   input  logic           reset,
   input  logic           ce,
   output logic [9:0]     fetch_h,
   output logic [9:0]     fetch_v,
   output logic           fetch_valid,
   output logic [9:0]     h_cnt,
   output logic [9:0]     v_cnt,
   output logic           valid,
   output logic           hsync,
   output logic           vsync,
   output logic           line_start,
   output logic           frame_start,
   output logic [FCW-1:0] frame_cnt
);

   // 11-bit counters/limits so totals up to 2047 compare without overflow.
   localparam logic [10:0] HD_C  = 11'(HD);
   localparam logic [10:0] HSB_C = 11'(HD + HF);
   localparam logic [10:0] HSE_C = 11'(HD + HF + HS);
   localparam logic [10:0] HT_M1 = 11'(HD + HF + HS + HB - 1);
   localparam logic [10:0] VD_C  = 11'(VD);
   localparam logic [10:0] VSB_C = 11'(VD + VF);
   localparam logic [10:0] VSE_C = 11'(VD + VF + VS);
   localparam logic [10:0] VT_M1 = 11'(VD + VF + VS + VB - 1);

   typedef struct packed {
      logic       vld;
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
   } disp_t;

   logic [10:0]    px_q, px_d;
   logic [10:0]    ln_q, ln_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

   logic  px_act, ln_act, hs_act, vs_act;
   disp_t cur_w;
   disp_t disp_w;

   // ---------------- counters ----------------
   always_comb begin
      px_d        = px_q;
      ln_d        = ln_q;
      frame_cnt_d = frame_cnt_q;
      if (ce) begin
         if (px_q == HT_M1) begin
            px_d = '0;
            if (ln_q == VT_M1) begin
               ln_d        = '0;
               frame_cnt_d = frame_cnt_q + FCW'(1);
            end else begin
               ln_d = ln_q + 11'd1;
            end
         end else begin
            px_d = px_q + 11'd1;
         end
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         px_q        <= '0;
         ln_q        <= '0;
         frame_cnt_q <= '0;
      end else begin
         px_q        <= px_d;
         ln_q        <= ln_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // ---------------- fetch side ----------------
   always_comb begin
      px_act = (px_q < HD_C);
      ln_act = (ln_q < VD_C);
      hs_act = (px_q >= HSB_C) && (px_q < HSE_C);
      vs_act = (ln_q >= VSB_C) && (ln_q < VSE_C);

      cur_w.vld = px_act && ln_act;
      cur_w.h   = px_act ? px_q[9:0] : '0;
      cur_w.v   = ln_act ? ln_q[9:0] : '0;
      cur_w.hs  = HSYNC_POL ? hs_act : ~hs_act;
      cur_w.vs  = VSYNC_POL ? vs_act : ~vs_act;
   end

   assign fetch_valid = cur_w.vld;
   assign fetch_h     = cur_w.h;
   assign fetch_v     = cur_w.v;

   // Pulses are qualified by reset so they stay low while reset is held,
   // even though the counters already sit at px=0, ln=0.
   assign line_start  = reset && ce && (px_q == '0) && (ln_q < VD_C);
   assign frame_start = reset && ce && (px_q == '0) && (ln_q == '0);
   assign frame_cnt   = frame_cnt_q;

   // ---------------- display pipeline ----------------
   if (LEAD == 0) begin : g_nopipe
      assign disp_w = cur_w;
   end else begin : g_pipe
      localparam disp_t BLANK = '{vld: 1'b0, h: 10'd0, v: 10'd0,
                                  hs: ~HSYNC_POL, vs: ~VSYNC_POL};
      disp_t pipe_q [LEAD];
      disp_t pipe_d [LEAD];

      always_comb begin
         for (int unsigned i = 0; i < LEAD; i++) pipe_d[i] = pipe_q[i];
         if (ce) begin
            pipe_d[0] = cur_w;
            for (int unsigned i = 1; i < LEAD; i++) pipe_d[i] = pipe_q[i-1];
         end
      end

      always_ff @(posedge pclk or negedge reset) begin
         if (!reset) begin
            for (int unsigned i = 0; i < LEAD; i++) pipe_q[i] <= BLANK;
         end else begin
            for (int unsigned i = 0; i < LEAD; i++) pipe_q[i] <= pipe_d[i];
         end
      end

      assign disp_w = pipe_q[LEAD-1];
   end

   assign valid = disp_w.vld;
   assign h_cnt = disp_w.h;
   assign v_cnt = disp_w.v;
   assign hsync = disp_w.hs;
   assign vsync = disp_w.vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster LEAD=0 FCW=2,
// small raster LEAD=2 with inverted syncs, default 640x480 raster).
module tb_vga_timing_gen;

   typedef struct packed {
      logic       vld;
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
   } disp_t;

   typedef struct {
      int         t;
      logic [9:0] fh;
      logic [9:0] fv;
      logic       vld;
      logic       hs;
      logic       vs;
      logic [1:0] fc;
   } vec_t;

   logic pclk = 1'b0;
   logic reset;
   logic ce;
   always #5 pclk = ~pclk;

   logic [9:0] a_fh, a_fv, a_hc, a_vc, b_fh, b_fv, b_hc, b_vc, c_fh, c_fv, c_hc, c_vc;
   logic a_fvld, a_vld, a_hs, a_vs, a_ls, a_fs;
   logic b_fvld, b_vld, b_hs, b_vs, b_ls, b_fs;
   logic c_fvld, c_vld, c_hs, c_vs, c_ls, c_fs;
   logic [1:0] a_fc;
   logic [7:0] b_fc, c_fc;

   vga_timing_gen #(.HD(8), .HF(2), .HS(3), .HB(2), .VD(4), .VF(1), .VS(2), .VB(1),
                    .LEAD(0), .FCW(2)) u_a (
      .pclk(pclk), .reset(reset), .ce(ce),
      .fetch_h(a_fh), .fetch_v(a_fv), .fetch_valid(a_fvld),
      .h_cnt(a_hc), .v_cnt(a_vc), .valid(a_vld), .hsync(a_hs), .vsync(a_vs),
      .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));

   vga_timing_gen #(.HD(8), .HF(2), .HS(3), .HB(2), .VD(4), .VF(1), .VS(2), .VB(1),
                    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LEAD(2), .FCW(8)) u_b (
      .pclk(pclk), .reset(reset), .ce(ce),
      .fetch_h(b_fh), .fetch_v(b_fv), .fetch_valid(b_fvld),
      .h_cnt(b_hc), .v_cnt(b_vc), .valid(b_vld), .hsync(b_hs), .vsync(b_vs),
      .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));

   vga_timing_gen u_c (
      .pclk(pclk), .reset(reset), .ce(ce),
      .fetch_h(c_fh), .fetch_v(c_fv), .fetch_valid(c_fvld),
      .h_cnt(c_hc), .v_cnt(c_vc), .valid(c_vld), .hsync(c_hs), .vsync(c_vs),
      .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc));

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_px, m_ln, m_fca, m_fcb, d_px, d_ln;
   disp_t sb[$];   // expected display values of u_b, oldest first

   function automatic logic [20:0] sm_fetch(int px, int ln);
      logic [9:0] h, v;
      h = (px < 8) ? 10'(px) : 10'd0;
      v = (ln < 4) ? 10'(ln) : 10'd0;
      return {h, v, (px < 8) && (ln < 4)};
   endfunction

   function automatic logic [1:0] sm_sync(int px, int ln, bit pol);
      bit hs, vs;
      hs = (px >= 10) && (px < 13);
      vs = (ln >= 5) && (ln < 7);
      return {pol ? hs : !hs, pol ? vs : !vs};
   endfunction

   function automatic disp_t b_entry(int px, int ln);
      disp_t e;
      e.vld = (px < 8) && (ln < 4);
      e.h   = (px < 8) ? 10'(px) : 10'd0;
      e.v   = (ln < 4) ? 10'(ln) : 10'd0;
      e.hs  = (px >= 10) && (px < 13);
      e.vs  = (ln >= 5) && (ln < 7);
      return e;
   endfunction

   function automatic logic [22:0] df_exp(int px, int ln);
      logic [9:0] h, v;
      h = (px < 640) ? 10'(px) : 10'd0;
      v = (ln < 480) ? 10'(ln) : 10'd0;
      return {h, v, (px < 640) && (ln < 480),
              !((px >= 656) && (px < 752)), !((ln >= 490) && (ln < 492))};
   endfunction

   function automatic logic [1:0] st_exp(logic r, logic c, int px, int ln, int vd);
      return {r && c && px == 0 && ln < vd, r && c && px == 0 && ln == 0};
   endfunction

   always @(posedge pclk or negedge reset) begin
      if (!reset) begin
         m_px <= 0; m_ln <= 0; m_fca <= 0; m_fcb <= 0; d_px <= 0; d_ln <= 0;
         sb.delete();
         sb.push_back('0);
         sb.push_back('0);
      end else if (ce) begin
         void'(sb.pop_front());
         sb.push_back(b_entry(m_px, m_ln));
         if (m_px == 14) begin
            m_px <= 0;
            if (m_ln == 7) begin
               m_ln  <= 0;
               m_fca <= (m_fca + 1) % 4;
               m_fcb <= (m_fcb + 1) % 256;
            end else m_ln <= m_ln + 1;
         end else m_px <= m_px + 1;
         if (d_px == 799) begin
            d_px <= 0;
            d_ln <= (d_ln == 524) ? 0 : d_ln + 1;
         end else d_px <= d_px + 1;
      end
   end

   // Continuous comparison of every output against the model.
   always @(negedge pclk) begin
      if (chk_en) begin
         chk("a_fetch", {a_fh, a_fv, a_fvld}, sm_fetch(m_px, m_ln));
         chk("a_disp", {a_hc, a_vc, a_vld, a_hs, a_vs}, {sm_fetch(m_px, m_ln), sm_sync(m_px, m_ln, 1'b0)});
         chk("a_ctl", {a_ls, a_fs, a_fc}, {st_exp(reset, ce, m_px, m_ln, 4), 2'(m_fca)});
         chk("b_fetch", {b_fh, b_fv, b_fvld}, sm_fetch(m_px, m_ln));
         chk("b_disp", {b_vld, b_hc, b_vc, b_hs, b_vs}, sb[0]);
         chk("b_ctl", {b_ls, b_fs, b_fc}, {st_exp(reset, ce, m_px, m_ln, 4), 8'(m_fcb)});
         chk("c_fetch", {c_fh, c_fv, c_fvld, c_hs, c_vs}, df_exp(d_px, d_ln));
         chk("c_disp", {c_hc, c_vc, c_vld}, {c_fh, c_fv, c_fvld} & 21'h0 | df_exp(d_px, d_ln) >> 2);
         chk("c_ctl", {c_ls, c_fs, c_fc}, {st_exp(reset, ce, d_px, d_ln, 480), 8'd0});
      end
   end

   task automatic step(input bit c);
      @(posedge pclk);
      #2 ce = c;
   endtask

   task automatic measure(input int p, input int exp_line, input int exp_frame);
      int c1 = -1, c2 = -1, f1 = -1, f2 = -1;
      for (int i = 0; i < 2 * exp_line + 10 * p; i++) begin
         @(posedge pclk);
         #2 ce = (i % p == 0);
         @(negedge pclk);
         if (c_ls) begin
            if (c1 < 0) c1 = i; else if (c2 < 0) c2 = i;
         end
         if (a_fs) begin
            if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
         end
         if (c2 >= 0 && f2 >= 0) break;
      end
      chk($sformatf("line_period_ce%0d", p), 64'((c2 < 0) ? -1 : c2 - c1), 64'(exp_line));
      chk($sformatf("frame_period_ce%0d", p), 64'((f2 < 0) ? -1 : f2 - f1), 64'(exp_frame));
   endtask

   vec_t vecs[17];
   int   cur;
   int   rf, rv;
   bit   prev_fv, prev_v;

   initial begin
      // t = ce ticks since reset release on the small raster (HT=15, VT=8)
      vecs[0]  = '{0,   10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[1]  = '{5,   10'd5, 10'd0, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[2]  = '{7,   10'd7, 10'd0, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[3]  = '{8,   10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[4]  = '{10,  10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd0};
      vecs[5]  = '{12,  10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd0};
      vecs[6]  = '{13,  10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[7]  = '{15,  10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[8]  = '{47,  10'd2, 10'd3, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[9]  = '{60,  10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[10] = '{75,  10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 2'd0};
      vecs[11] = '{101, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[12] = '{105, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[13] = '{119, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[14] = '{120, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 2'd1};
      vecs[15] = '{480, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 2'd0};
      vecs[16] = '{600, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 2'd1};

      reset = 1'b0;
      ce    = 1'b0;
      repeat (3) @(posedge pclk);
      chk_en = 1'b1;
      @(negedge pclk);
      chk("reset_state", {b_vld, b_hc, b_vc, b_hs, b_vs, a_ls, a_fs, a_fc, b_fc, a_fvld}, 64'd1);
      @(posedge pclk);
      #3 reset = 1'b1;

      cur = 0;
      for (int i = 0; i < 17; i++) begin
         repeat (vecs[i].t - cur) step(1'b1);
         step(1'b0);
         cur = vecs[i].t;
         @(negedge pclk);
         chk($sformatf("vec%0d", i), {a_fh, a_fv, a_fvld, a_hs, a_vs, a_fc},
             {vecs[i].fh, vecs[i].fv, vecs[i].vld, vecs[i].hs, vecs[i].vs, vecs[i].fc});
      end

      // Mid-frame asynchronous reset, observed before any clock edge.
      repeat (37) step(1'b1);
      @(posedge pclk);
      #3 reset = 1'b0;
      #1;
      chk("rst_b_disp", {b_vld, b_hc, b_vc, b_hs, b_vs}, 64'd0);
      chk("rst_ctl", {a_ls, a_fs, b_ls, b_fs, c_ls, c_fs, a_fc, b_fc, c_fc}, 64'd0);
      chk("rst_pos", {a_fh, a_fv, c_fh, c_fv, a_fvld}, 64'd1);
      repeat (3) @(posedge pclk);
      #3 reset = 1'b1;
      @(negedge pclk);
      chk("first_frame_start", {a_fs, b_fs, c_fs, a_ls, c_ls}, 64'h1f);

      // LEAD=2 alignment: valid follows fetch_valid by two ticks.
      prev_fv = b_fvld;
      prev_v  = b_vld;
      rf = -1;
      rv = -1;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge pclk);
         if (b_fvld && !prev_fv && rf < 0) rf = cyc;
         if (b_vld && !prev_v && rf >= 0 && rv < 0) rv = cyc;
         if (b_fh == 10'd5) chk("lead_h_cnt", b_hc, 64'd3);
         prev_fv = b_fvld;
         prev_v  = b_vld;
      end
      chk("lead_latency", 64'((rf < 0 || rv < 0) ? -1 : rv - rf), 64'd2);

      measure(1, 800, 120);
      measure(4, 3200, 480);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      n_err++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1);
   end

endmodule
